// File: rtl/chimp_round_ctrl.sv
// Round/level sequencer for the chimp memory test: clears and loads the board, runs the
// show/play phases, scores each round and tracks level, strikes and game over.
module chimp_round_ctrl #(
    parameter int START_LEVEL   = 4,
    parameter int MAX_LEVEL     = 31,
    parameter int MAX_STRIKES   = 3,
    parameter int RESULT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iStart,
    input  logic       iAbort,
    input  logic       iDoneLoad,
    input  logic       iChoseCorrect,
    input  logic       iChoseWrong,
    output logic       oResetBoard,
    output logic       oLoadEnable,
    output logic [4:0] oNumToLoad,
    output logic       oShowEnable,
    output logic [4:0] oNumToChoose,
    output logic [4:0] oLevel,
    output logic [1:0] oStrikes,
    output logic       oRoundPass,
    output logic       oGameOver,
    output logic       oGameWon,
    output logic [2:0] oDbgState
);
    localparam int            CW        = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(RESULT_CYCLES - 1);
    localparam logic [4:0]    LVL_START = 5'(START_LEVEL);
    localparam logic [4:0]    LVL_MAX   = 5'(MAX_LEVEL);
    localparam logic [1:0]    STK_MAX   = 2'(MAX_STRIKES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD   = 3'd2,
        S_SHOW   = 3'd3,
        S_PLAY   = 3'd4,
        S_RESULT = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass_q, pass_d;
    logic          reset_board_q, reset_board_d;
    logic          load_en_q, load_en_d;
    logic [4:0]    num_load_q, num_load_d;
    logic          show_q, show_d;
    logic [4:0]    num_choose_q, num_choose_d;
    logic [4:0]    level_q, level_d;
    logic [1:0]    strikes_q, strikes_d;
    logic          round_pass_q, round_pass_d;
    logic          over_q, over_d;
    logic          won_q, won_d;
    logic [1:0]    strikes_inc;

    // Load handshake: oLoadEnable stays high while oNumToLoad is pending; each iDoneLoad
    // seen in LOAD acknowledges exactly one number and advances to the next one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pass_d       = pass_q;
        num_load_d   = num_load_q;
        num_choose_d = num_choose_q;
        level_d      = level_q;
        strikes_d    = strikes_q;
        won_d        = won_q;
        round_pass_d = 1'b0;
        strikes_inc  = strikes_q + 2'd1;

        if (iAbort) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            pass_d       = 1'b0;
            num_load_d   = '0;
            num_choose_d = '0;
            level_d      = LVL_START;
            strikes_d    = '0;
            won_d        = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (iStart) begin
                        state_d   = S_CLEAR;
                        level_d   = LVL_START;
                        strikes_d = '0;
                        won_d     = 1'b0;
                    end
                end
                S_CLEAR: begin
                    state_d    = S_LOAD;
                    num_load_d = 5'd1;
                end
                S_LOAD: begin
                    if (iDoneLoad) begin
                        if (num_load_q == level_q) begin
                            state_d      = S_SHOW;
                            num_choose_d = 5'd1;
                        end else begin
                            num_load_d = num_load_q + 5'd1;
                        end
                    end
                end
                S_SHOW, S_PLAY: begin
                    // A simultaneous correct and wrong pulse counts as wrong.
                    if (iChoseWrong) begin
                        state_d = S_RESULT;
                        pass_d  = 1'b0;
                        cnt_d   = '0;
                    end else if (iChoseCorrect) begin
                        if (num_choose_q == level_q) begin
                            state_d = S_RESULT;
                            pass_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d      = S_PLAY;
                            num_choose_d = num_choose_q + 5'd1;
                        end
                    end
                end
                S_RESULT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (pass_q) begin
                            round_pass_d = 1'b1;
                            if (level_q == LVL_MAX) begin
                                state_d = S_OVER;
                                won_d   = 1'b1;
                            end else begin
                                state_d = S_CLEAR;
                                level_d = level_q + 5'd1;
                            end
                        end else begin
                            strikes_d = strikes_inc;
                            state_d   = (strikes_inc == STK_MAX) ? S_OVER : S_CLEAR;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Output flags are derived from the next state so they are registered alongside it.
        reset_board_d = iAbort || (state_d == S_CLEAR);
        load_en_d     = (state_d == S_LOAD);
        show_d        = (state_d == S_SHOW) || (state_d == S_RESULT) || (state_d == S_OVER);
        over_d        = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pass_q        <= 1'b0;
            reset_board_q <= 1'b0;
            load_en_q     <= 1'b0;
            num_load_q    <= '0;
            show_q        <= 1'b0;
            num_choose_q  <= '0;
            level_q       <= LVL_START;
            strikes_q     <= '0;
            round_pass_q  <= 1'b0;
            over_q        <= 1'b0;
            won_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pass_q        <= pass_d;
            reset_board_q <= reset_board_d;
            load_en_q     <= load_en_d;
            num_load_q    <= num_load_d;
            show_q        <= show_d;
            num_choose_q  <= num_choose_d;
            level_q       <= level_d;
            strikes_q     <= strikes_d;
            round_pass_q  <= round_pass_d;
            over_q        <= over_d;
            won_q         <= won_d;
        end
    end

    assign oResetBoard  = reset_board_q;
    assign oLoadEnable  = load_en_q;
    assign oNumToLoad   = num_load_q;
    assign oShowEnable  = show_q;
    assign oNumToChoose = num_choose_q;
    assign oLevel       = level_q;
    assign oStrikes     = strikes_q;
    assign oRoundPass   = round_pass_q;
    assign oGameOver    = over_q;
    assign oGameWon     = won_q;
    assign oDbgState    = state_q;

endmodule

// File: tb/tb_chimp_round_ctrl.sv
// Scoreboard bench for chimp_round_ctrl: directed rounds push expected output events,
// a negedge monitor detects events on the DUT outputs and compares them in order.
module tb_chimp_round_ctrl;
    localparam int RC   = 4;
    localparam int MAXL = 5;
    localparam int W    = 19;

    localparam logic [2:0] EV_CLR    = 3'd1;
    localparam logic [2:0] EV_PASS   = 3'd2;
    localparam logic [2:0] EV_RES    = 3'd3;
    localparam logic [2:0] EV_OVER   = 3'd4;
    localparam logic [2:0] EV_LOAD   = 3'd5;
    localparam logic [2:0] EV_CHOOSE = 3'd6;
    localparam logic [2:0] ST_RESULT = 3'd5;

    localparam logic [4:0] START = 5'b10000;
    localparam logic [4:0] DONE  = 5'b01000;
    localparam logic [4:0] CORR  = 5'b00100;
    localparam logic [4:0] WRNG  = 5'b00010;
    localparam logic [4:0] ABRT  = 5'b00001;

    logic       clk = 1'b0;
    logic       iResetn;
    logic       iStart, iAbort, iDoneLoad, iChoseCorrect, iChoseWrong;
    logic       oResetBoard, oLoadEnable, oShowEnable, oRoundPass, oGameOver, oGameWon;
    logic [4:0] oNumToLoad, oNumToChoose, oLevel;
    logic [1:0] oStrikes;
    logic [2:0] oDbgState;

    logic [W-1:0] exp_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [4:0]   m_choose = '0;

    chimp_round_ctrl #(
        .START_LEVEL(4), .MAX_LEVEL(MAXL), .MAX_STRIKES(3), .RESULT_CYCLES(RC)
    ) dut (
        .clk(clk), .iResetn(iResetn), .iStart(iStart), .iAbort(iAbort),
        .iDoneLoad(iDoneLoad), .iChoseCorrect(iChoseCorrect), .iChoseWrong(iChoseWrong),
        .oResetBoard(oResetBoard), .oLoadEnable(oLoadEnable), .oNumToLoad(oNumToLoad),
        .oShowEnable(oShowEnable), .oNumToChoose(oNumToChoose), .oLevel(oLevel),
        .oStrikes(oStrikes), .oRoundPass(oRoundPass), .oGameOver(oGameOver),
        .oGameWon(oGameWon), .oDbgState(oDbgState)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [2:0] code, input logic [4:0] lvl,
                                        input logic [1:0] stk, input logic [4:0] val,
                                        input logic show, input logic load,
                                        input logic over, input logic won);
        return {code, lvl, stk, val, show, load, over, won};
    endfunction

    function automatic string ev_name(input logic [2:0] code);
        case (code)
            EV_CLR:    return "clear";
            EV_PASS:   return "round_pass";
            EV_RES:    return "result_len";
            EV_OVER:   return "game_over";
            EV_LOAD:   return "load_req";
            EV_CHOOSE: return "num_to_choose";
            default:   return "unknown";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic check_event(input logic [W-1:0] got);
        logic [W-1:0] want;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected %s event: got %h want none", ev_name(got[W-1 -: 3]), got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s event at %0t: got %h want %h", ev_name(want[W-1 -: 3]),
                         $time, got, want);
            end
        end
    endtask

    // monitor
    logic       prev_load = 1'b0, prev_over = 1'b0;
    logic [4:0] prev_num = '0, prev_choose = '0, res_cnt = '0;
    logic [2:0] prev_state = '0;

    function automatic logic [W-1:0] snap(input logic [2:0] code, input logic [4:0] val);
        return mk(code, oLevel, oStrikes, val, oShowEnable, oLoadEnable, oGameOver, oGameWon);
    endfunction

    always @(negedge clk) begin
        if (!iResetn) begin
            prev_load   = 1'b0;
            prev_over   = 1'b0;
            prev_num    = '0;
            prev_choose = oNumToChoose;
            prev_state  = '0;
            res_cnt     = '0;
        end else begin
            if (oResetBoard) check_event(snap(EV_CLR, oNumToChoose));
            if (oRoundPass) check_event(snap(EV_PASS, 5'd0));
            if (oDbgState == ST_RESULT) begin
                res_cnt = res_cnt + 5'd1;
            end else if (prev_state == ST_RESULT) begin
                check_event(snap(EV_RES, res_cnt));
                res_cnt = '0;
            end
            if (oGameOver && !prev_over) check_event(snap(EV_OVER, 5'd0));
            if (oLoadEnable && (!prev_load || oNumToLoad != prev_num))
                check_event(snap(EV_LOAD, oNumToLoad));
            if (oNumToChoose != prev_choose && oNumToChoose != 5'd0)
                check_event(snap(EV_CHOOSE, oNumToChoose));
            prev_load   = oLoadEnable;
            prev_over   = oGameOver;
            prev_num    = oNumToLoad;
            prev_choose = oNumToChoose;
            prev_state  = oDbgState;
        end
    end

    // drivers
    task automatic drive(input logic [4:0] v);
        {iStart, iDoneLoad, iChoseCorrect, iChoseWrong, iAbort} = v;
        @(posedge clk);
        #1;
        {iStart, iDoneLoad, iChoseCorrect, iChoseWrong, iAbort} = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_game;
        exp_q.push_back(mk(EV_CLR, 5'd4, 2'd0, m_choose, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(EV_LOAD, 5'd4, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(START);
    endtask

    task automatic load_all(input logic [4:0] lvl, input logic [1:0] stk);
        for (int k = 1; k <= int'(lvl); k++) begin
            idle(2);
            if (k < int'(lvl)) begin
                exp_q.push_back(mk(EV_LOAD, lvl, stk, 5'(k + 1), 1'b0, 1'b1, 1'b0, 1'b0));
            end else begin
                if (m_choose != 5'd1)
                    exp_q.push_back(mk(EV_CHOOSE, lvl, stk, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
                m_choose = 5'd1;
            end
            drive(DONE);
        end
    endtask

    task automatic play_pass(input logic [4:0] lvl, input logic [1:0] stk);
        for (int c = 1; c < int'(lvl); c++) begin
            m_choose = 5'(c + 1);
            exp_q.push_back(mk(EV_CHOOSE, lvl, stk, m_choose, 1'b0, 1'b0, 1'b0, 1'b0));
            drive(CORR);
        end
        if (int'(lvl) == MAXL) begin
            exp_q.push_back(mk(EV_PASS, lvl, stk, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
            exp_q.push_back(mk(EV_RES, lvl, stk, 5'(RC), 1'b1, 1'b0, 1'b1, 1'b1));
            exp_q.push_back(mk(EV_OVER, lvl, stk, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1));
        end else begin
            exp_q.push_back(mk(EV_CLR, lvl + 5'd1, stk, m_choose, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(EV_PASS, lvl + 5'd1, stk, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(EV_RES, lvl + 5'd1, stk, 5'(RC), 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(EV_LOAD, lvl + 5'd1, stk, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        drive(CORR);
        idle(RC + 3);
    endtask

    task automatic play_fail(input logic [4:0] lvl, input logic [1:0] stk,
                             input int ncorrect, input logic [4:0] last);
        logic [1:0] s;
        for (int c = 0; c < ncorrect; c++) begin
            m_choose = m_choose + 5'd1;
            exp_q.push_back(mk(EV_CHOOSE, lvl, stk, m_choose, 1'b0, 1'b0, 1'b0, 1'b0));
            drive(CORR);
        end
        s = stk + 2'd1;
        if (s == 2'd3) begin
            exp_q.push_back(mk(EV_RES, lvl, s, 5'(RC), 1'b1, 1'b0, 1'b1, 1'b0));
            exp_q.push_back(mk(EV_OVER, lvl, s, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        end else begin
            exp_q.push_back(mk(EV_CLR, lvl, s, m_choose, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(EV_RES, lvl, s, 5'(RC), 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(EV_LOAD, lvl, s, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        end
        drive(last);
        idle(RC + 3);
    endtask

    // stimulus
    initial begin
        {iStart, iDoneLoad, iChoseCorrect, iChoseWrong, iAbort} = '0;
        iResetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_level", 32'(oLevel), 32'd4);
        check("reset_outputs", 32'({oResetBoard, oLoadEnable, oNumToLoad, oShowEnable,
              oNumToChoose, oStrikes, oRoundPass, oGameOver, oGameWon}), 32'd0);
        @(posedge clk);
        #1;
        iResetn = 1'b1;
        idle(2);

        // round 1: level 4 passes, with ignored inputs sprinkled in
        start_game();
        idle(1);
        drive(CORR | WRNG);
        load_all(5'd4, 2'd0);
        drive(DONE);
        drive(START);
        play_pass(5'd4, 2'd0);

        // three failed rounds at level 5 lead to game over
        load_all(5'd5, 2'd0);
        play_fail(5'd5, 2'd0, 1, WRNG);
        load_all(5'd5, 2'd1);
        play_fail(5'd5, 2'd1, 0, CORR | WRNG);
        load_all(5'd5, 2'd2);
        play_fail(5'd5, 2'd2, 1, WRNG);
        drive(DONE);

        // restart, then abort mid-load
        start_game();
        idle(1);
        exp_q.push_back(mk(EV_LOAD, 5'd4, 2'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(DONE);
        idle(1);
        exp_q.push_back(mk(EV_CLR, 5'd4, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_choose = 5'd0;
        drive(ABRT | DONE);
        idle(2);
        drive(CORR);

        // two passed rounds win the game at the top level
        start_game();
        load_all(5'd4, 2'd0);
        play_pass(5'd4, 2'd0);
        load_all(5'd5, 2'd0);
        play_pass(5'd5, 2'd0);
        idle(3);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d pending want 0", exp_q.size());
        end

        // asynchronous reset from game over
        @(posedge clk);
        #2;
        iResetn = 1'b0;
        #1;
        check("async_reset_level", 32'(oLevel), 32'd4);
        check("async_reset_flags", 32'({oResetBoard, oShowEnable, oGameOver, oGameWon,
              oStrikes}), 32'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
